// File: rtl/lt4_bank_writer.sv
// rtl/lt4_bank_writer.sv - sequences nibble writes into eight transparent latches sharing one data bus
module lt4_bank_writer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_addr,
    input  logic [3:0]  req_data,
    output logic [3:0]  lat_d,
    output logic [7:0]  lat_ng,
    output logic [31:0] shadow,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Phase counter is loaded with (length - 1) and a phase ends when it reaches zero.
    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

    state_t     state;
    logic [3:0] phase;
    logic [2:0] addr;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            phase  <= 4'd0;
            addr   <= 3'd0;
            lat_d  <= 4'h0;
            lat_ng <= 8'hFF;
            shadow <= 32'h0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr  <= req_addr;
                        lat_d <= req_data;
                        phase <= SETUP_LAST;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase == 4'd0) begin
                        lat_ng <= ~(8'd1 << addr);
                        phase  <= STROBE_LAST;
                        state  <= STROBE;
                    end else begin
                        phase <= phase - 4'd1;
                    end
                end
                STROBE: begin
                    if (phase == 4'd0) begin
                        // The latch closes on this edge, so the mirror takes the value now.
                        lat_ng                    <= 8'hFF;
                        shadow[{addr, 2'b00} +: 4] <= lat_d;
                        phase                     <= HOLD_LAST;
                        state                     <= HOLD;
                    end else begin
                        phase <= phase - 4'd1;
                    end
                end
                HOLD: begin
                    if (phase == 4'd0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        phase <= phase - 4'd1;
                    end
                end
                default: begin
                    lat_ng <= 8'hFF;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lt4_bank_writer.sv
// tb/tb_lt4_bank_writer.sv - directed self-checking bench for lt4_bank_writer
module tb_lt4_bank_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid2 = 1'b0;
    logic [2:0]  req_addr = 3'd0;
    logic [3:0]  req_data = 4'h0;

    logic        req_ready, busy, done;
    logic [3:0]  lat_d;
    logic [7:0]  lat_ng;
    logic [31:0] shadow;

    logic        req_ready2, busy2, done2;
    logic [3:0]  lat_d2;
    logic [7:0]  lat_ng2;
    logic [31:0] shadow2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lt4_bank_writer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .lat_d(lat_d), .lat_ng(lat_ng),
        .shadow(shadow), .busy(busy), .done(done)
    );

    lt4_bank_writer #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_addr(req_addr), .req_data(req_data), .lat_d(lat_d2), .lat_ng(lat_ng2),
        .shadow(shadow2), .busy(busy2), .done(done2)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({req_ready, busy, done, lat_d, lat_ng, shadow} !== {1'b1, 1'b0, 1'b0, 4'h0, 8'hFF, 32'h0}) begin
            bad++;
            $display("FAIL reset_state got ready=%b busy=%b done=%b d=%h ng=%h sh=%h", req_ready, busy, done, lat_d, lat_ng, shadow);
        end
    endtask

    task automatic test_single();
        logic [7:0]  exp_ng;
        logic [31:0] exp_sh;
        reset = 1'b0;
        req_valid = 1'b1; req_addr = 3'd3; req_data = 4'hA;
        step();
        req_valid = 1'b0;
        total++;
        if (lat_d !== 4'hA || lat_ng !== 8'hFF || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_accept got d=%h ng=%h busy=%b want d=a ng=ff busy=1", lat_d, lat_ng, busy);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            exp_ng = (i == 1 || i == 2) ? 8'hF7 : 8'hFF;
            exp_sh = (i >= 3) ? 32'h0000A000 : 32'h0;
            total++;
            if (lat_ng !== exp_ng || shadow !== exp_sh || done !== (i == 4) || lat_d !== 4'hA) begin
                bad++;
                $display("FAIL single_edge%0d got ng=%h sh=%h done=%b d=%h want ng=%h sh=%h done=%b d=a",
                         i, lat_ng, shadow, done, lat_d, exp_ng, exp_sh, (i == 4));
            end
        end
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got ready=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_ng;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b1; req_addr = 3'd0; req_data = 4'h1;
        step();
        req_addr = 3'd7; req_data = 4'hF;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 5) req_valid = 1'b0;
            exp_ng = (i == 1 || i == 2) ? 8'hFE : (i == 6 || i == 7) ? 8'h7F : 8'hFF;
            total++;
            if (lat_ng !== exp_ng || done !== (i == 4 || i == 9) || $countones(~lat_ng) > 1) begin
                bad++;
                $display("FAIL b2b_edge%0d got ng=%h done=%b want ng=%h done=%b",
                         i, lat_ng, done, exp_ng, (i == 4 || i == 9));
            end
            if (i == 5) begin
                total++;
                if (busy !== 1'b1 || lat_d !== 4'hF) begin
                    bad++;
                    $display("FAIL b2b_second_accept got busy=%b d=%h want 1 f", busy, lat_d);
                end
            end
        end
        total++;
        if (shadow !== 32'hF0000001) begin
            bad++;
            $display("FAIL b2b_shadow got %h want f0000001", shadow);
        end
    endtask

    task automatic test_reset_mid_strobe();
        req_valid = 1'b1; req_addr = 3'd5; req_data = 4'h6;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        total++;
        if (lat_ng !== 8'hDF) begin
            bad++;
            $display("FAIL midrst_strobe got ng=%h want df", lat_ng);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (lat_ng !== 8'hFF || shadow !== 32'h0 || lat_d !== 4'h0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_async got ng=%h sh=%h d=%h ready=%b want ff 0 0 1", lat_ng, shadow, lat_d, req_ready);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || lat_ng !== 8'hFF) begin
            bad++;
            $display("FAIL midrst_nodone got done=%b ng=%h want 0 ff", done, lat_ng);
        end
        reset = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            step();
            req_valid = 1'b0;
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL midrst_first_edge_accept got busy=%b want 1", busy);
                end
            end
        end
        total++;
        if (done !== 1'b1 || shadow !== 32'h00600000) begin
            bad++;
            $display("FAIL midrst_rewrite got done=%b sh=%h want 1 00600000", done, shadow);
        end
    endtask

    task automatic test_params();
        int low_cnt = 0;
        req_valid2 = 1'b1; req_addr = 3'd2; req_data = 4'h9;
        step();
        req_valid2 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (lat_ng2 == 8'hFB) low_cnt++;
            total++;
            if (lat_ng2 !== ((i >= 3 && i <= 6) ? 8'hFB : 8'hFF) || done2 !== (i == 9)) begin
                bad++;
                $display("FAIL params_edge%0d got ng=%h done=%b want ng=%h done=%b",
                         i, lat_ng2, done2, ((i >= 3 && i <= 6) ? 8'hFB : 8'hFF), (i == 9));
            end
        end
        total++;
        if (low_cnt != 4 || shadow2 !== 32'h00000900) begin
            bad++;
            $display("FAIL params_summary got low=%0d sh=%h want 4 00000900", low_cnt, shadow2);
        end
    endtask

    task automatic test_capture();
        for (int rep = 0; rep < 2; rep++) begin
            req_valid = 1'b1; req_addr = 3'd4; req_data = 4'hC;
            step();
            req_valid = 1'b0; req_addr = 3'd1; req_data = 4'h3;
            for (int i = 1; i <= 4; i++) begin
                step();
                total++;
                if (lat_ng !== ((i == 1 || i == 2) ? 8'hEF : 8'hFF) || lat_d !== 4'hC) begin
                    bad++;
                    $display("FAIL capture_rep%0d_edge%0d got ng=%h d=%h want ng=%h d=c",
                             rep, i, lat_ng, lat_d, ((i == 1 || i == 2) ? 8'hEF : 8'hFF));
                end
            end
            total++;
            if (shadow !== 32'h006C0000 || done !== 1'b1) begin
                bad++;
                $display("FAIL capture_rep%0d_shadow got sh=%h done=%b want 006c0000 1", rep, shadow, done);
            end
        end
        for (int i = 0; i < 5; i++) begin
            req_addr = 3'(i); req_data = 4'(i + 5);
            step();
            total++;
            if (lat_ng !== 8'hFF || req_ready !== 1'b1 || shadow !== 32'h006C0000) begin
                bad++;
                $display("FAIL idle_novalid_%0d got ng=%h ready=%b sh=%h want ff 1 006c0000", i, lat_ng, req_ready, shadow);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_strobe();
        test_params();
        test_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
